// File: rtl/param_lru_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : param_lru_icache_pkg
// Purpose  : Shared definitions for the LRU instruction cache: default
//            widths, bus command encodings, FSM state encoding and a
//            constant-evaluable clog2 helper.
// Revision : 1.0 - initial release
// ============================================================================
package param_lru_icache_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CMD_W  = 3;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CMD  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_lru_icache_if.sv
`default_nettype none
// ============================================================================
// Module   : param_lru_icache_if
// Purpose  : Host fetch port plus system-bus fill port of the instruction
//            cache, bundled as one interface.
// Modports : master - host/arbiter/memory side (drives requests, grant, fill)
//            slave  - cache side (drives results and the bus request)
// Revision : 1.0 - initial release
// ============================================================================
interface param_lru_icache_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int CMD_W  = 3
);
  logic [ADDR_W-1:0] cache_host_addr;
  logic [CMD_W-1:0]  cache_host_cmd;
  logic              cache_request;
  logic              cache_flush;
  logic              cache_bus_grant;
  logic [DATA_W-1:0] cache_datain;
  logic              cache_datain_valid;
  logic [DATA_W-1:0] cache_dataout;
  logic              cache_ready;
  logic              cache_hit;
  logic              cache_miss;
  logic              cache_busy;
  logic              cache_bus_request;
  logic [ADDR_W-1:0] cache_addr;
  logic [CMD_W-1:0]  cache_cmd;

  modport master (
    output cache_host_addr, cache_host_cmd, cache_request, cache_flush,
           cache_bus_grant, cache_datain, cache_datain_valid,
    input  cache_dataout, cache_ready, cache_hit, cache_miss, cache_busy,
           cache_bus_request, cache_addr, cache_cmd
  );

  modport slave (
    input  cache_host_addr, cache_host_cmd, cache_request, cache_flush,
           cache_bus_grant, cache_datain, cache_datain_valid,
    output cache_dataout, cache_ready, cache_hit, cache_miss, cache_busy,
           cache_bus_request, cache_addr, cache_cmd
  );
endinterface
`default_nettype wire

// File: rtl/param_lru_icache_lru_age_set.sv
`default_nettype none
// ============================================================================
// Module   : lru_age_set
// Purpose  : Combinational true-LRU update and victim choice for one set.
//            Ages are distinct, 0 = most recently used. State lives in the
//            parent; this block only computes the next ages and the victim.
// Ports    : ages_in/ages_out - current/updated age per way
//            access_valid, access_way - way being touched this cycle
//            invalid - per-way invalid flags, victim - way to replace
// Revision : 1.0 - initial release
// ============================================================================
module lru_age_set #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages_in,
  input  logic                       access_valid,
  input  logic [AGE_W-1:0]           access_way,
  input  logic [WAYS-1:0]            invalid,
  output logic [AGE_W-1:0]           victim,
  output logic [WAYS-1:0][AGE_W-1:0] ages_out
);

  logic [AGE_W-1:0] acc_age;
  logic             found;

  assign acc_age = ages_in[access_way];

  // Ways younger than the accessed one age by one; accessed way becomes MRU.
  always_comb begin
    ages_out = ages_in;
    if (access_valid) begin
      for (int i = 0; i < WAYS; i++) begin
        if (ages_in[i] < acc_age) ages_out[i] = ages_in[i] + 1'b1;
      end
      ages_out[access_way] = '0;
    end
  end

  // Lowest-index invalid way wins; otherwise the oldest way.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (invalid[i] && !found) begin
        victim = AGE_W'(i);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (ages_in[i] == AGE_W'(WAYS - 1)) victim = AGE_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_lru_icache.sv
`default_nettype none
// ============================================================================
// Module   : param_lru_icache
// Purpose  : N-way set-associative instruction cache with true LRU
//            replacement, single-cycle hits, bus request/grant line fill,
//            host-write invalidation and full flush.
// Ports    : clk0, reset (sync, active high)
//            bus (slave modport) - host fetch port and bus fill port
// Revision : 1.0 - initial release
// ============================================================================
module param_lru_icache
  import param_lru_icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CMD_W  = DEF_CMD_W,
  parameter int WAYS   = 4,
  parameter int SETS   = 32
) (
  input  logic                clk0,
  input  logic                reset,
  param_lru_icache_if.slave   bus
);

  localparam int INDEX_W = clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int AGE_W   = clog2(WAYS);

  state_t                      state;
  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0][AGE_W-1:0]  age_q   [SETS];
  logic [TAG_W-1:0]            tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]           data_q  [SETS][WAYS];

  logic [ADDR_W-1:0] fill_addr;
  logic [AGE_W-1:0]  victim_q;
  logic              flush_pend;
  logic [DATA_W-1:0] dataout_q;
  logic              ready_q, hit_q, miss_q, busy_q, bus_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CMD_W-1:0]  cmd_q;

  logic [INDEX_W-1:0] host_idx, fill_idx, sel_idx;
  logic [TAG_W-1:0]   host_tag, fill_tag;
  logic [WAYS-1:0]    hit_vec;
  logic [AGE_W-1:0]   hit_way, victim, acc_way;
  logic               hit_any, is_read, is_write, do_flush, lookup_hit, fill_now;
  logic [WAYS-1:0][AGE_W-1:0] ages_upd;

  assign host_idx = bus.cache_host_addr[INDEX_W-1:0];
  assign host_tag = bus.cache_host_addr[ADDR_W-1:INDEX_W];
  assign fill_idx = fill_addr[INDEX_W-1:0];
  assign fill_tag = fill_addr[ADDR_W-1:INDEX_W];
  assign is_read  = bus.cache_host_cmd == CMD_W'(CMD_READ);
  assign is_write = bus.cache_host_cmd == CMD_W'(CMD_WRITE);
  assign do_flush = bus.cache_flush || flush_pend;

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit_vec[i] = valid_q[host_idx][i] && (tag_q[host_idx][i] == host_tag);
      if (hit_vec[i]) hit_way = AGE_W'(i);
    end
  end
  assign hit_any = |hit_vec;

  assign lookup_hit = (state == ST_IDLE) && !do_flush && bus.cache_request && is_read && hit_any;
  assign fill_now   = (state == ST_WAIT) && bus.cache_datain_valid;

  // Only one set is touched per cycle: the host set in IDLE, the fill set in WAIT.
  assign sel_idx = (state == ST_WAIT) ? fill_idx : host_idx;
  assign acc_way = (state == ST_WAIT) ? victim_q : hit_way;

  lru_age_set #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .ages_in      (age_q[sel_idx]),
    .access_valid (lookup_hit || fill_now),
    .access_way   (acc_way),
    .invalid      (~valid_q[sel_idx]),
    .victim       (victim),
    .ages_out     (ages_upd)
  );

  always_ff @(posedge clk0) begin
    if (reset) begin
      state      <= ST_IDLE;
      fill_addr  <= '0;
      victim_q   <= '0;
      flush_pend <= 1'b0;
      dataout_q  <= '0;
      ready_q    <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      busy_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int i = 0; i < WAYS; i++) age_q[s][i] <= AGE_W'(i);
      end
    end else begin
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      // A flush seen mid-fill is deferred until the fill has installed.
      if (bus.cache_flush && state != ST_IDLE) flush_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (do_flush) begin
            flush_pend <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              for (int i = 0; i < WAYS; i++) age_q[s][i] <= AGE_W'(i);
            end
          end else if (bus.cache_request) begin
            if (is_read) begin
              if (hit_any) begin
                hit_q            <= 1'b1;
                ready_q          <= 1'b1;
                dataout_q        <= data_q[host_idx][hit_way];
                age_q[host_idx]  <= ages_upd;
              end else begin
                miss_q    <= 1'b1;
                fill_addr <= bus.cache_host_addr;
                victim_q  <= victim;
                busy_q    <= 1'b1;
                bus_req_q <= 1'b1;
                state     <= ST_REQ;
              end
            end else if (is_write && hit_any) begin
              valid_q[host_idx][hit_way] <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (bus.cache_bus_grant) begin
            bus_req_q <= 1'b0;
            addr_q    <= fill_addr;
            cmd_q     <= CMD_W'(CMD_READ);
            state     <= ST_CMD;
          end
        end
        ST_CMD: begin
          addr_q <= '0;
          cmd_q  <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.cache_datain_valid) begin
            valid_q[fill_idx][victim_q] <= 1'b1;
            age_q[fill_idx]             <= ages_upd;
            ready_q                     <= 1'b1;
            dataout_q                   <= bus.cache_datain;
            busy_q                      <= 1'b0;
            state                       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk0) begin
    if (!reset && fill_now) begin
      tag_q[fill_idx][victim_q]  <= fill_tag;
      data_q[fill_idx][victim_q] <= bus.cache_datain;
    end
  end

  assign bus.cache_dataout     = dataout_q;
  assign bus.cache_ready       = ready_q;
  assign bus.cache_hit         = hit_q;
  assign bus.cache_miss        = miss_q;
  assign bus.cache_busy        = busy_q;
  assign bus.cache_bus_request = bus_req_q;
  assign bus.cache_addr        = addr_q;
  assign bus.cache_cmd         = cmd_q;

endmodule
`default_nettype wire

// File: tb/tb_param_lru_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_lru_icache
// Purpose  : Directed self-checking bench for param_lru_icache
//            (24-bit address, 32-bit data, 4 ways, 32 sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_lru_icache;

  logic clk0 = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk0 = ~clk0;

  param_lru_icache_if #(.ADDR_W(24), .DATA_W(32), .CMD_W(3)) bus_if ();

  param_lru_icache #(
    .ADDR_W(24), .DATA_W(32), .CMD_W(3), .WAYS(4), .SETS(32)
  ) dut (
    .clk0  (clk0),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic req(input logic [23:0] addr, input logic [2:0] cmd);
    bus_if.cache_host_addr = addr;
    bus_if.cache_host_cmd  = cmd;
    bus_if.cache_request   = 1'b1;
  endtask

  // Set-3 address for a given tag (5 index bits).
  function automatic logic [23:0] a3(input int t);
    return 24'((t << 5) | 3);
  endfunction

  task automatic do_hit(input string tag, input logic [23:0] addr, input logic [31:0] data);
    req(addr, 3'b001);
    tick();
    bus_if.cache_request = 1'b0;
    check_eq({tag, "_hit"}, 32'(bus_if.cache_hit), 32'd1);
    check_eq({tag, "_miss"}, 32'(bus_if.cache_miss), 32'd0);
    check_eq({tag, "_data"}, bus_if.cache_dataout, data);
  endtask

  task automatic do_fill(input string tag, input logic [23:0] addr, input logic [31:0] data);
    req(addr, 3'b001);
    tick();
    bus_if.cache_request = 1'b0;
    check_eq({tag, "_miss"}, 32'(bus_if.cache_miss), 32'd1);
    check_eq({tag, "_busreq"}, 32'(bus_if.cache_bus_request), 32'd1);
    bus_if.cache_bus_grant = 1'b1;
    tick();
    bus_if.cache_bus_grant = 1'b0;
    check_eq({tag, "_addr"}, 32'(bus_if.cache_addr), 32'(addr));
    tick();
    bus_if.cache_datain       = data;
    bus_if.cache_datain_valid = 1'b1;
    tick();
    bus_if.cache_datain_valid = 1'b0;
    check_eq({tag, "_fready"}, 32'(bus_if.cache_ready), 32'd1);
    check_eq({tag, "_fdata"}, bus_if.cache_dataout, data);
    check_eq({tag, "_fbusy"}, 32'(bus_if.cache_busy), 32'd0);
  endtask

  initial begin
    bus_if.cache_host_addr    = '0;
    bus_if.cache_host_cmd     = '0;
    bus_if.cache_request      = 1'b0;
    bus_if.cache_flush        = 1'b0;
    bus_if.cache_bus_grant    = 1'b0;
    bus_if.cache_datain       = '0;
    bus_if.cache_datain_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_busy", 32'(bus_if.cache_busy), 32'd0);
    check_eq("rst_ready", 32'(bus_if.cache_ready), 32'd0);
    check_eq("rst_busreq", 32'(bus_if.cache_bus_request), 32'd0);
    check_eq("rst_cmd", 32'(bus_if.cache_cmd), 32'd0);

    // 1: first miss with delayed grant, then hit on the same address.
    req(24'h000123, 3'b001);
    tick();
    bus_if.cache_request = 1'b0;
    check_eq("t1_miss", 32'(bus_if.cache_miss), 32'd1);
    check_eq("t1_busy", 32'(bus_if.cache_busy), 32'd1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req(24'h000123, 3'b001);  // request while busy
      tick();
      bus_if.cache_request = 1'b0;
      check_eq("t1_req_hold", 32'(bus_if.cache_bus_request), 32'd1);
      check_eq("t1_busy_nohit", 32'(bus_if.cache_hit | bus_if.cache_miss), 32'd0);
    end
    bus_if.cache_bus_grant = 1'b1;
    tick();
    bus_if.cache_bus_grant = 1'b0;
    check_eq("t1_cmd_addr", 32'(bus_if.cache_addr), 32'h000123);
    check_eq("t1_cmd_cmd", 32'(bus_if.cache_cmd), 32'd1);
    check_eq("t1_cmd_busreq", 32'(bus_if.cache_bus_request), 32'd0);
    tick();
    check_eq("t1_wait_cmd", 32'(bus_if.cache_cmd), 32'd0);
    check_eq("t1_wait_addr", 32'(bus_if.cache_addr), 32'd0);
    bus_if.cache_datain       = 32'hDEADBEEF;
    bus_if.cache_datain_valid = 1'b1;
    tick();
    bus_if.cache_datain_valid = 1'b0;
    check_eq("t1_fill_ready", 32'(bus_if.cache_ready), 32'd1);
    check_eq("t1_fill_data", bus_if.cache_dataout, 32'hDEADBEEF);
    check_eq("t1_fill_hit", 32'(bus_if.cache_hit), 32'd0);
    do_hit("t1_rehit", 24'h000123, 32'hDEADBEEF);
    check_eq("t1_rehit_ready", 32'(bus_if.cache_ready), 32'd1);
    check_eq("t1_rehit_busreq", 32'(bus_if.cache_bus_request), 32'd0);

    // 6b: flush and read together in IDLE -> flush only, no pulses.
    bus_if.cache_flush = 1'b1;
    req(24'h000123, 3'b001);
    tick();
    bus_if.cache_flush   = 1'b0;
    bus_if.cache_request = 1'b0;
    check_eq("t6_flush_miss", 32'(bus_if.cache_miss), 32'd0);
    check_eq("t6_flush_hit", 32'(bus_if.cache_hit), 32'd0);
    check_eq("t6_flush_busy", 32'(bus_if.cache_busy), 32'd0);

    // 2: LRU replacement in set 3.
    for (int t = 1; t <= 4; t++) do_fill($sformatf("t2_f%0d", t), a3(t), 32'hA0000000 | 32'(t));
    do_hit("t2_h1", a3(1), 32'hA0000001);
    do_fill("t2_f5", a3(5), 32'hA0000005);  // evicts tag 2
    do_hit("t2_h3", a3(3), 32'hA0000003);
    do_hit("t2_h4", a3(4), 32'hA0000004);
    do_hit("t2_h5", a3(5), 32'hA0000005);
    do_fill("t2_f2", a3(2), 32'hA0000002);  // tag 2 was the evicted line; evicts tag 1 now? no: LRU is tag 1
    // After the hits above tag 1 is the oldest, so tag 1 misses while 3,4,5,2 hit.
    do_hit("t2_h2", a3(2), 32'hA0000002);
    do_hit("t2_h5b", a3(5), 32'hA0000005);

    // 3: write-invalidate tag 4, refill it; the rest of the set still hits.
    req(a3(4), 3'b010);
    tick();
    bus_if.cache_request = 1'b0;
    check_eq("t3_wr_quiet", 32'(bus_if.cache_hit | bus_if.cache_miss | bus_if.cache_ready), 32'd0);
    do_fill("t3_refill", a3(4), 32'hB0000004);
    do_hit("t3_h3", a3(3), 32'hA0000003);
    do_hit("t3_h2", a3(2), 32'hA0000002);
    do_hit("t3_h4", a3(4), 32'hB0000004);

    // 4: flush raised during WAIT completes the fill, then flushes.
    req(24'h000040, 3'b001);
    tick();
    bus_if.cache_request   = 1'b0;
    bus_if.cache_bus_grant = 1'b1;
    tick();
    bus_if.cache_bus_grant = 1'b0;
    tick();
    bus_if.cache_flush = 1'b1;
    tick();
    bus_if.cache_flush        = 1'b0;
    bus_if.cache_datain       = 32'h12345678;
    bus_if.cache_datain_valid = 1'b1;
    tick();
    bus_if.cache_datain_valid = 1'b0;
    check_eq("t4_ready", 32'(bus_if.cache_ready), 32'd1);
    check_eq("t4_data", bus_if.cache_dataout, 32'h12345678);
    req(24'h000040, 3'b001);  // ignored while the deferred flush runs
    tick();
    bus_if.cache_request = 1'b0;
    check_eq("t4_flushcyc", 32'(bus_if.cache_hit | bus_if.cache_miss), 32'd0);
    do_fill("t4_m40", 24'h000040, 32'h12345678);
    do_fill("t4_m3", a3(3), 32'hA0000003);

    // 5: reset in REQ and in WAIT discards the fill.
    req(24'h000555, 3'b001);
    tick();
    bus_if.cache_request = 1'b0;
    check_eq("t5_req_busreq", 32'(bus_if.cache_bus_request), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_rreq_busreq", 32'(bus_if.cache_bus_request), 32'd0);
    check_eq("t5_rreq_busy", 32'(bus_if.cache_busy), 32'd0);
    bus_if.cache_datain       = 32'hCAFEF00D;
    bus_if.cache_datain_valid = 1'b1;
    tick();
    bus_if.cache_datain_valid = 1'b0;
    check_eq("t5_late_ready", 32'(bus_if.cache_ready), 32'd0);
    do_fill("t5_again", 24'h000555, 32'hCAFEF00D);
    req(24'h000666, 3'b001);
    tick();
    bus_if.cache_request   = 1'b0;
    bus_if.cache_bus_grant = 1'b1;
    tick();
    bus_if.cache_bus_grant = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_rwait_busy", 32'(bus_if.cache_busy), 32'd0);
    check_eq("t5_rwait_busreq", 32'(bus_if.cache_bus_request), 32'd0);
    bus_if.cache_datain_valid = 1'b1;
    tick();
    bus_if.cache_datain_valid = 1'b0;
    check_eq("t5_rwait_ready", 32'(bus_if.cache_ready), 32'd0);
    req(24'h000666, 3'b001);
    tick();
    bus_if.cache_request = 1'b0;
    check_eq("t5_rwait_miss", 32'(bus_if.cache_miss), 32'd1);
    req(24'h000555, 3'b001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.cache_request = 1'b0;
    check_eq("t5_final_busy", 32'(bus_if.cache_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_lru_icache.md
Name: param_lru_icache

Overview:
- Parametrised N-way set-associative instruction cache with true LRU replacement.
- Sits between the CPU fetch port and the system bus arbiter.
- Hits return in one cycle. Misses run a bus request/grant line fill, install the line into the LRU or invalid victim way, and forward the fetched word.
- Supports host-write invalidation (self-modifying code) and a full flush.

Parameters:
ADDR_W, 24, host/bus address width (padd_size)
DATA_W, 32, instruction word width (data_size)
CMD_W, 3, command width (cmd_size); 3'b001 = read, 3'b010 = write
WAYS, 4, associativity, power of two, 2..8
SETS, 32, sets per way, power of two; INDEX_W = log2(SETS), TAG_W = ADDR_W - INDEX_W

Ports:
clk0  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cache_host_addr  in  ADDR_W  fetch/write address; index = [INDEX_W-1:0], tag = [ADDR_W-1:INDEX_W]
cache_host_cmd  in  CMD_W  host command
cache_request  in  1  host request qualifier; sampled only when cache_busy = 0
cache_flush  in  1  invalidate all lines
cache_bus_grant  in  1  arbiter grant
cache_datain  in  DATA_W  fill data from memory
cache_datain_valid  in  1  fill data valid strobe
cache_dataout  out  DATA_W  instruction to host; valid while cache_ready = 1
cache_ready  out  1  one-cycle pulse: cache_dataout valid
cache_hit  out  1  one-cycle pulse on lookup hit
cache_miss  out  1  one-cycle pulse on lookup miss
cache_busy  out  1  high in every state except IDLE
cache_bus_request  out  1  high in REQ state
cache_addr  out  ADDR_W  fill address; driven in CMD state, 0 otherwise
cache_cmd  out  CMD_W  3'b001 in CMD state, 0 otherwise

Behaviour:
- Reset (sync): state IDLE; all valid bits 0; LRU age of way i = i in every set; all outputs 0.
- Storage: per way/set a valid bit, TAG_W tag and DATA_W word. Lookup is combinational on the registered arrays.
- LRU: each set holds WAYS distinct ages (log2(WAYS) bits each), 0 = MRU.
  - On access to way w with age a: every way with age < a increments; w becomes 0.
  - Update applies on a hit and on a fill install.
- Victim selection: lowest-index invalid way; if none, the way with age WAYS-1.
- FSM states: IDLE, REQ, CMD, WAIT.
- IDLE:
  - cache_flush = 1: clear all valids and reset ages; any request in the same cycle is ignored (flush has priority).
  - request with cmd 001, hit: next cycle cache_hit = 1, cache_ready = 1, cache_dataout = hit word; LRU updated; stay IDLE. Latency is 1.
  - request with cmd 001, miss: latch addr and victim way; next cycle cache_miss = 1 and state = REQ.
  - request with cmd 010: clear the valid bit of the matching way (if any); no LRU change, no outputs; stay IDLE.
  - other cmd values: ignored.
- REQ: cache_bus_request = 1 until cache_bus_grant = 1, then go to CMD.
- CMD: one cycle; cache_addr = latched addr, cache_cmd = 3'b001; go to WAIT.
- WAIT: on cache_datain_valid, write valid = 1, tag and data into the victim way.
  - Same edge: LRU update, cache_ready = 1, cache_dataout = cache_datain, cache_hit = 0; return to IDLE.
  - No timeout.
- cache_flush outside IDLE: latched as pending; the fill completes and installs, then the flush executes on the first IDLE cycle. A request in that cycle is ignored.
- Reset in any state: next edge goes to IDLE, drops bus_request/addr/cmd and discards the fill; arrays revert to reset values.
- Grant arriving outside REQ is ignored. Data valid arriving outside WAIT is ignored.

Decomposition:
- Shared package holds:
  - command encodings CMD_READ = 3'b001, CMD_WRITE = 3'b010;
  - FSM state encoding;
  - function clog2;
  - default widths (24/32/3).
- One natural sub-module, lru_age_set: per-set age array.
  - Inputs: access valid, accessed way, invalid-way vector.
  - Outputs: victim way, updated ages.
  - Purely combinational update; state is held in the parent.

Test Plan:
1. Reset, then read addr 24'h000123 → cache_miss pulse; bus_request = 1; hold grant low 3 cycles, request stays 1; grant → CMD cycle with cache_addr = 24'h000123, cache_cmd = 3'b001; datain 32'hDEADBEEF valid → cache_ready = 1 with dataout DEADBEEF. Re-read same address → cache_hit and ready the next cycle, dataout DEADBEEF, no bus_request.
2. WAYS = 4: fill index 3 with tags 1,2,3,4 (ways 0..3); read tag 1 (hit); miss tag 5 → installs into way 1 (tag 2, LRU); then tag 2 misses and tag 1 hits.
3. Write cmd 3'b010 to a cached address → next read of it misses and fills; other ways of that set still hit.
4. Assert cache_flush during WAIT → fill completes with cache_ready, flush executes next cycle; all subsequent reads miss.
5. Assert reset in REQ and in WAIT → next cycle bus_request = 0, cache_busy = 0; late datain_valid ignored; the address still misses.
6. Request asserted while cache_busy = 1 → ignored (no hit/miss pulse). Simultaneous flush and read in IDLE → flush only; no miss pulse.
